// File: rtl/frontend_fetch_ctrl.sv
// Fetch sequencer for the frontend's one-entry instruction buffer and fetch PC.
// Latency: registered state; imem_data->cdata and redirect->out_valid are combinational.
// Backpressure: stall holds every register; redirect overrides stall and select.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   imem_data         : instruction word at fpc (combinational from imem)
//   sel_result/sel_req: select decision and "buffer was empty" flag
//   stall             : decode not accepting this cycle
//   redirect/_pc      : branch redirect and its target address
//   fpc, cdata        : fetch address / current word presented to the select
//   bpc, bf           : buffered slot presented to the select
//   out_valid, state  : select output is real this cycle; 0=REFILL 1=RUN
// Optional macro FRONTEND_PERF_EN adds perf_swap, perf_nop, perf_bubble counters.

`ifndef INSERT_NOP
`define INSERT_NOP 2'b00
`endif
`ifndef POP_DATA
`define POP_DATA 2'b01
`endif
`ifndef POP_BUF
`define POP_BUF 2'b10
`endif

module frontend_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] imem_data,
   input  logic [1:0]  sel_result,
   input  logic        sel_req,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] fpc,
   output logic [31:0] cdata,
   output logic [31:0] bpc,
   output logic [31:0] bf,
   output logic        out_valid,
   output logic        state
`ifdef FRONTEND_PERF_EN
   ,
   output logic [31:0] perf_swap,
   output logic [31:0] perf_nop,
   output logic [31:0] perf_bubble
`endif
);

   typedef enum logic {REFILL = 1'b0, RUN = 1'b1} state_t;

   state_t      cur_state, nxt_state;
   logic [31:0] fpc_q, fpc_d;
   logic [31:0] bpc_q, bpc_d;
   logic [31:0] bf_q,  bf_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= REFILL;
         fpc_q     <= RESET_PC;
         bpc_q     <= '0;
         bf_q      <= '0;
      end else begin
         cur_state <= nxt_state;
         fpc_q     <= fpc_d;
         bpc_q     <= bpc_d;
         bf_q      <= bf_d;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      fpc_d     = fpc_q;
      bpc_d     = bpc_q;
      bf_d      = bf_q;
      if (redirect) begin
         // Flush the buffer and restart fetch at the target; alignment untouched.
         fpc_d     = redirect_pc;
         bpc_d     = '0;
         bf_d      = '0;
         nxt_state = REFILL;
      end else if (!stall) begin
         if (cur_state == REFILL) begin
            bpc_d     = fpc_q;
            bf_d      = imem_data;
            fpc_d     = fpc_q + 32'd4;
            nxt_state = RUN;
         end else begin
            case (sel_result)
               // Buffer issued; keep fpc so the same C is offered again.
               `INSERT_NOP: bf_d = '0;
               // C issued ahead of B; if B was already a nop, refill next.
               `POP_DATA: begin
                  fpc_d = fpc_q + 32'd4;
                  if (sel_req) nxt_state = REFILL;
               end
               // Buffer issued and C moves into it.
               `POP_BUF: begin
                  bpc_d = fpc_q;
                  bf_d  = imem_data;
                  fpc_d = fpc_q + 32'd4;
               end
               default: ;  // reserved code behaves as a stall
            endcase
         end
      end
   end

   assign fpc       = fpc_q;
   assign cdata     = imem_data;
   assign bpc       = bpc_q;
   assign bf        = bf_q;
   assign state     = cur_state;
   assign out_valid = (cur_state == RUN) && !redirect;

`ifdef FRONTEND_PERF_EN
   logic run_go;
   assign run_go = (cur_state == RUN) && !stall && !redirect;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_swap   <= '0;
         perf_nop    <= '0;
         perf_bubble <= '0;
      end else begin
         if (run_go && sel_result == `POP_DATA && !sel_req && bf_q != '0)
            perf_swap <= perf_swap + 32'd1;
         if (run_go && sel_result == `INSERT_NOP)
            perf_nop <= perf_nop + 32'd1;
         // Bubbles count every REFILL cycle, stalled or not.
         if (cur_state == REFILL)
            perf_bubble <= perf_bubble + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_frontend_fetch_ctrl.sv
// Bench for frontend_fetch_ctrl: directed scenarios then randomized steps,
// each cycle compared against a behavioural model of the fetch rules.

`ifndef INSERT_NOP
`define INSERT_NOP 2'b00
`endif
`ifndef POP_DATA
`define POP_DATA 2'b01
`endif
`ifndef POP_BUF
`define POP_BUF 2'b10
`endif

module tb_frontend_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [1:0]  S_NOP  = `INSERT_NOP;
   localparam logic [1:0]  S_DATA = `POP_DATA;
   localparam logic [1:0]  S_BUF  = `POP_BUF;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_data;
   logic [1:0]  sel_result;
   logic        sel_req;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] fpc, cdata, bpc, bf;
   logic        out_valid;
   logic        state;
`ifdef FRONTEND_PERF_EN
   logic [31:0] perf_swap, perf_nop, perf_bubble;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   // Model state
   logic [31:0] m_fpc, m_bpc, m_bf, m_swap, m_nop, m_bub;
   bit          m_run;

   always #5 clk = ~clk;

   // Instruction memory contents; never zero so a fetched word is never a nop.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h1234, 16'hBEEF};
   endfunction

   assign imem_data = mem_word(fpc);

   frontend_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset), .imem_data(imem_data),
      .sel_result(sel_result), .sel_req(sel_req), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .fpc(fpc), .cdata(cdata), .bpc(bpc), .bf(bf),
      .out_valid(out_valid), .state(state)
`ifdef FRONTEND_PERF_EN
      , .perf_swap(perf_swap), .perf_nop(perf_nop), .perf_bubble(perf_bubble)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("fpc", fpc, m_fpc);
      chk("bpc", bpc, m_bpc);
      chk("bf", bf, m_bf);
      chk("cdata", cdata, mem_word(m_fpc));
      chk("state", {31'b0, state}, {31'b0, m_run});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_run && !redirect});
`ifdef FRONTEND_PERF_EN
      chk("perf_swap", perf_swap, m_swap);
      chk("perf_nop", perf_nop, m_nop);
      chk("perf_bubble", perf_bubble, m_bub);
`endif
   endtask

   // Effect of one clock edge, from the currently driven inputs.
   task automatic model_clock();
      logic [31:0] cur_word;
      cur_word = mem_word(m_fpc);
      if (reset) begin
         m_fpc = RST_PC; m_bpc = 0; m_bf = 0; m_run = 0;
         m_swap = 0; m_nop = 0; m_bub = 0;
      end else begin
         if (!m_run) m_bub++;
         if (redirect) begin
            m_fpc = redirect_pc; m_bpc = 0; m_bf = 0; m_run = 0;
         end else if (!stall) begin
            if (!m_run) begin
               m_bpc = m_fpc; m_bf = cur_word; m_fpc += 4; m_run = 1;
            end else if (sel_result == S_NOP) begin
               m_nop++;
               m_bf = 0;
            end else if (sel_result == S_DATA) begin
               if (!sel_req && m_bf != 0) m_swap++;
               m_fpc += 4;
               if (sel_req) m_run = 0;
            end else if (sel_result == S_BUF) begin
               m_bpc = m_fpc; m_bf = cur_word; m_fpc += 4;
            end
         end
      end
   endtask

   task automatic step(input logic rst, input logic st, input logic rd,
                       input logic [31:0] rpc, input logic [1:0] sr, input logic rq);
      reset = rst; stall = st; redirect = rd; redirect_pc = rpc;
      sel_result = sr; sel_req = rq;
      #1;
      check_all();
      model_clock();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1; stall = 0; redirect = 0; redirect_pc = 0; sel_result = S_BUF; sel_req = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      model_clock();
      reset = 0;
   endtask

   initial begin
      // Perf scenario: 5 swaps, 2 nops, 1 redirect.
      do_reset();
      chk("reset_fpc", fpc, 32'h0000_3000);
      chk("reset_bf", bf, 32'h0);
      step(0, 0, 0, 0, S_BUF, 0);                       // REFILL bubble
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, S_DATA, 0);
      step(0, 0, 0, 0, S_NOP, 0);
      step(0, 0, 0, 0, S_NOP, 0);
      step(0, 0, 1, 32'h0000_3100, S_BUF, 0);           // redirect
      step(0, 0, 0, 0, S_BUF, 0);                       // REFILL bubble
`ifdef FRONTEND_PERF_EN
      chk("perf5_swap", perf_swap, 32'd5);
      chk("perf2_nop", perf_nop, 32'd2);
      chk("perf2_bubble", perf_bubble, 32'd2);
`endif

      // Reset / first issue, nop insertion, refill, stall, redirect under stall.
      do_reset();
      step(0, 0, 0, 0, S_BUF, 0);                       // out_valid 0, load A
      chk("first_bf_A", bf, mem_word(32'h3000));
      chk("first_fpc", fpc, 32'h3004);
      step(0, 0, 0, 0, S_BUF, 0);                       // out_valid 1, issue A
      step(0, 0, 0, 0, S_NOP, 0);
      chk("nop_bf", bf, 32'h0);
      chk("nop_fpc_hold", fpc, 32'h3008);
      step(0, 0, 0, 0, S_DATA, 1);                      // -> REFILL
      chk("refill_fpc", fpc, 32'h300C);
      step(0, 0, 0, 0, S_BUF, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, S_BUF, 0);
      step(0, 0, 0, 0, S_BUF, 0);
      chk("post_stall_fpc", fpc, 32'h3014);
      step(0, 1, 1, 32'h0000_4000, S_BUF, 0);
      chk("redirect_fpc", fpc, 32'h4000);
      step(0, 0, 0, 0, S_BUF, 0);                       // out_valid 0 checked here

      // Wraparound at top of address space.
      step(0, 0, 1, 32'hFFFF_FFF8, S_BUF, 0);
      step(0, 0, 0, 0, S_BUF, 0);                       // fpc -> FFFF_FFFC
      step(0, 0, 0, 0, S_DATA, 0);
      chk("wrap_fpc", fpc, 32'h0);
      step(0, 0, 0, 0, 2'b11, 0);                       // reserved code holds

      // Randomized traffic including mid-run resets.
      for (int i = 0; i < 800; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 9) == 0, rpc, 2'($urandom), 1'($urandom));
      end
      #1;
      check_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/frontend_fetch_ctrl.md
# frontend_fetch_ctrl

Sequencing controller for the pipeline frontend's one-entry instruction buffer and fetch PC. It owns the buffered slot `{bpc, bf}` and the fetch address `fpc`, and presents both to the frontend select logic together with the instruction-memory word. Each cycle it acts on the select's `result`/`req` decision. It also handles downstream stall, branch redirect, and buffer refill after the buffer empties.

## Interface
- `RESET_PC`, default `32'h0000_3000`: fetch address loaded at reset.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `imem_data`  in  32: instruction word at `fpc`, combinational from instruction memory.
- `sel_result`  in  2: select decision, one of `` `INSERT_NOP `` / `` `POP_DATA `` / `` `POP_BUF ``.
- `sel_req`  in  1: select reports the buffer held a nop (empty) when it issued C.
- `stall`  in  1: decode not accepting this cycle.
- `redirect`  in  1: branch resolved taken or mispredicted.
- `redirect_pc`  in  32: new fetch address, valid with `redirect`.
- `fpc`  out  32: fetch address to instruction memory; also the select's `cpc`.
- `cdata`  out  32: `imem_data` passed through to the select's `data`.
- `bpc`, `bf`  out  32 each: buffered slot to the select.
- `out_valid`  out  1: the select's emitted `{pc, instr}` is a real instruction this cycle.
- `state`  out  1: `0` = REFILL, `1` = RUN, for debug.

## Operation
- Two states: REFILL and RUN. `bf == 0` means the buffer is empty (nop).
- REFILL:
  - `out_valid = 0`; `sel_result` is ignored.
  - If `!stall && !redirect`: `bpc ← fpc`, `bf ← imem_data`, `fpc ← fpc + 4`, go to RUN.
- RUN:
  - `out_valid = !redirect`.
  - If `!stall && !redirect`, act on `sel_result`:
    - `` `INSERT_NOP ``: B is issued. `bf ← 0`; `bpc` and `fpc` hold, so C is re-presented next cycle.
    - `` `POP_DATA `` with `sel_req = 0`: C is issued ahead of B. `fpc ← fpc + 4`; B holds.
    - `` `POP_DATA `` with `sel_req = 1`: C is issued and the buffer is empty. `fpc ← fpc + 4`; go to REFILL.
    - `` `POP_BUF ``: B is issued. `bpc ← fpc`, `bf ← imem_data`, `fpc ← fpc + 4`.
    - Undefined code `2'b11`: treat as a stall (hold all state).
- `stall` without `redirect`: all registers hold in every state.
- `redirect` in any state, with or without `stall`: `fpc ← redirect_pc`, `bf ← 0`, `bpc ← 0`, go to REFILL.
  - `redirect` has priority over `stall` and over `sel_result`.
- PC arithmetic is 32-bit modulo; `32'hFFFF_FFFC + 4` wraps to `0` with no flag.
- Alignment is not checked; `redirect_pc[1:0]` is carried through unchanged.

## Timing
- Reset values: `fpc = RESET_PC`, `bpc = 0`, `bf = 0`, `state = REFILL`, `out_valid = 0`, counters `0`.
- First valid issue is 2 cycles after reset deasserts: one cycle of REFILL, then RUN.
- Redirect penalty: 1 bubble cycle (REFILL) before the first instruction from `redirect_pc` issues.
- `out_valid`, `fpc`, `cdata`, `bpc`, `bf` are registered or pass-through. The only combinational paths are `imem_data` → `cdata`, and `redirect` → `out_valid`.
- Next-state logic depends combinationally on `sel_result`/`sel_req`. The loop `imem_data` → select → controller must close in one cycle.
- Reset asserted mid-operation overrides `redirect` and `stall` on that edge.

## Configuration
- `FRONTEND_PERF_EN` defined adds three 32-bit outputs:
  - `perf_swap`: increments on each non-stalled RUN cycle with `` `POP_DATA ``, `sel_req = 0` and `bf != 0`.
  - `perf_nop`: increments on each non-stalled `` `INSERT_NOP ``.
  - `perf_bubble`: increments on each cycle in REFILL.
  - All three reset to `0`, wrap modulo 2^32, and hold during `stall`, except that `perf_bubble` still counts stalled REFILL cycles.
- `FRONTEND_PERF_EN` undefined: the ports and counters are absent; the remaining behaviour is identical.

## Test plan
- Reset, `RESET_PC = 32'h3000`, memory word `A` at `3000`, `B` at `3004`, `sel_result = POP_BUF` → cycle 0: `out_valid = 0`. Cycle 1: `bf = A`, `fpc = 3004`, `out_valid = 1`.
- RUN, `bf = branch`, `sel_result = INSERT_NOP` → next cycle `bf = 0` and `fpc` unchanged. Then `sel_result = POP_DATA`, `sel_req = 1` → state REFILL, `fpc += 4`.
- RUN, `stall = 1` for 3 cycles with `sel_result = POP_BUF` → `fpc`, `bpc`, `bf` unchanged. First cycle after release: `fpc += 4`.
- `redirect = 1`, `redirect_pc = 32'h4000`, same cycle as `stall = 1` → next cycle `fpc = 4000`, `bf = 0`, state REFILL, `out_valid = 0`.
- `fpc = 32'hFFFF_FFFC`, `sel_result = POP_DATA`, `sel_req = 0` → `fpc = 0`.
- `FRONTEND_PERF_EN`: 5 swaps, 2 inserted nops, 1 redirect → `perf_swap = 5`, `perf_nop = 2`, `perf_bubble = 2` (reset plus redirect). With the macro undefined, the same stimulus gives identical `fpc`/`out_valid` traces.
